// File: rtl/set.sv
// Grid-point set counter: scans the 64 points of an 8x8 grid against three
// circles and counts the points that satisfy the selected set relation.
module set (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] central,
    input  logic [11:0] radius,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  candidate
);

    localparam int unsigned CW   = 4;
    localparam int unsigned IW   = 7;
    localparam int unsigned SW   = 9;
    localparam int unsigned CNTW = 8;
    localparam int unsigned NPTS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [23:0]     cen_q;
    logic [11:0]     rad_q;
    logic [1:0]      mode_q;
    logic [IW-1:0]   idx;
    logic [CNTW-1:0] cnt;

    logic [CW-1:0]   px_c;
    logic [CW-1:0]   py_c;
    logic            in_a_c;
    logic            in_b_c;
    logic            in_c_c;
    logic            hit_c;

    // Squared-distance test; all terms unsigned, sum is 9 bits so it cannot overflow.
    function automatic logic inside_circle(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic [CW-1:0] cx,
        input logic [CW-1:0] cy,
        input logic [CW-1:0] r
    );
        logic [7:0]    dx;
        logic [7:0]    dy;
        logic [7:0]    rr;
        logic [SW-1:0] d2;
        logic [SW-1:0] r2;
        dx = (x >= cx) ? {4'd0, x - cx} : {4'd0, cx - x};
        dy = (y >= cy) ? {4'd0, y - cy} : {4'd0, cy - y};
        rr = {4'd0, r};
        d2 = {1'b0, dx * dx} + {1'b0, dy * dy};
        r2 = {1'b0, rr * rr};
        return d2 <= r2;
    endfunction

    // Row-major walk: x advances fastest, both coordinates run 1..8.
    always_comb begin
        px_c   = {1'b0, idx[2:0]} + 4'd1;
        py_c   = {1'b0, idx[5:3]} + 4'd1;
        in_a_c = inside_circle(px_c, py_c, cen_q[23:20], cen_q[19:16], rad_q[11:8]);
        in_b_c = inside_circle(px_c, py_c, cen_q[15:12], cen_q[11:8],  rad_q[7:4]);
        in_c_c = inside_circle(px_c, py_c, cen_q[7:4],   cen_q[3:0],   rad_q[3:0]);
        hit_c  = 1'b0;
        case (mode_q)
            2'b00:   hit_c = in_a_c;
            2'b01:   hit_c = in_a_c & in_b_c;
            2'b10:   hit_c = in_a_c ^ in_b_c;
            default: hit_c = (2'(in_a_c) + 2'(in_b_c) + 2'(in_c_c)) == 2'd2;
        endcase
    end

    // Job sequencer: one point per CALC cycle, result published from DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            candidate <= '0;
            cnt       <= '0;
            idx       <= '0;
            cen_q     <= '0;
            rad_q     <= '0;
            mode_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (en) begin
                        cen_q  <= central;
                        rad_q  <= radius;
                        mode_q <= mode;
                        cnt    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (idx == IW'(NPTS)) begin
                        candidate <= cnt;
                        valid     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNTW'(hit_c);
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set.sv
// Directed bench for the grid-point set counter.
module tb_set;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;

    int checks;
    int errors;

    set dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pack_cen(input int xa, input int ya, input int xb,
                                             input int yb, input int xc, input int yc);
        return {4'(xa), 4'(ya), 4'(xb), 4'(yb), 4'(xc), 4'(yc)};
    endfunction

    function automatic logic [11:0] pack_rad(input int ra, input int rb, input int rc);
        return {4'(ra), 4'(rb), 4'(rc)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one job; optionally disturbs inputs and pulses en mid-job.
    task automatic run_job(input string tag, input logic [23:0] c, input logic [11:0] r,
                           input logic [1:0] m, input int exp, input bit perturb);
        int lat;
        int nvalid;
        logic busy_at_valid;
        lat = 0;
        nvalid = 0;
        busy_at_valid = 1'b0;
        @(negedge clk);
        central = c;
        radius  = r;
        mode    = m;
        en      = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        for (int n = 1; n <= 66; n++) begin
            @(posedge clk);
            #1;
            if (perturb && n == 10) begin
                central = ~c;
                radius  = 12'hfff;
                mode    = ~m;
                en      = 1'b1;
            end
            if (perturb && n == 11) en = 1'b0;
            if (valid) begin
                nvalid++;
                if (lat == 0) begin
                    lat = n;
                    busy_at_valid = busy;
                end
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd65);
        check({tag, "_nvalid"}, 32'(nvalid), 32'd1);
        check({tag, "_busy_at_valid"}, 32'(busy_at_valid), 32'd1);
        check({tag, "_candidate"}, 32'(candidate), 32'(exp));
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {23'd0, valid, candidate}, {23'd0, 1'b0, 8'(exp)});
    endtask

    initial begin
        int stray;
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        en      = 1'b1;
        central = '0;
        radius  = '0;
        mode    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {22'd0, busy, valid, candidate}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;

        run_job("m0_r0",      pack_cen(4, 4, 0, 0, 0, 0),   pack_rad(0, 0, 0),   2'b00, 1,  1'b0);
        run_job("m0_r15",     pack_cen(4, 4, 0, 0, 0, 0),   pack_rad(15, 0, 0),  2'b00, 64, 1'b0);
        run_job("m0_r1_bnd",  pack_cen(4, 4, 0, 0, 0, 0),   pack_rad(1, 0, 0),   2'b00, 5,  1'b0);
        run_job("m1_disjoint",pack_cen(1, 1, 8, 8, 0, 0),   pack_rad(1, 1, 0),   2'b01, 0,  1'b0);
        run_job("m2_same",    pack_cen(4, 4, 4, 4, 0, 0),   pack_rad(2, 2, 0),   2'b10, 0,  1'b0);
        run_job("m1_same",    pack_cen(4, 4, 4, 4, 0, 0),   pack_rad(2, 2, 0),   2'b01, 13, 1'b0);
        run_job("m2_corners", pack_cen(1, 1, 8, 8, 0, 0),   pack_rad(1, 1, 0),   2'b10, 6,  1'b0);
        run_job("m3_all",     pack_cen(4, 4, 4, 4, 4, 4),   pack_rad(15, 15, 15),2'b11, 0,  1'b0);
        run_job("m3_c0",      pack_cen(4, 4, 4, 4, 4, 4),   pack_rad(15, 15, 0), 2'b11, 63, 1'b0);
        run_job("m3_pair",    pack_cen(4, 4, 5, 4, 15, 15), pack_rad(1, 1, 0),   2'b11, 2,  1'b0);
        run_job("m0_off_lo",  pack_cen(0, 0, 0, 0, 0, 0),   pack_rad(3, 0, 0),   2'b00, 4,  1'b0);
        run_job("m0_off_hi",  pack_cen(9, 9, 0, 0, 0, 0),   pack_rad(2, 0, 0),   2'b00, 1,  1'b0);
        run_job("perturb",    pack_cen(4, 4, 0, 0, 0, 0),   pack_rad(0, 0, 0),   2'b00, 1,  1'b1);

        // Abort a job mid-scan with reset.
        @(negedge clk);
        central = pack_cen(4, 4, 0, 0, 0, 0);
        radius  = pack_rad(15, 0, 0);
        mode    = 2'b00;
        en      = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_state", {22'd0, busy, valid, candidate}, 32'd0);
        rst = 1'b1;
        run_job("after_abort", pack_cen(4, 4, 4, 4, 0, 0), pack_rad(2, 2, 0), 2'b01, 13, 1'b0);

        stray = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (valid || busy) stray++;
        end
        check("idle_quiet", 32'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
